// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the fetch/decode stage: FSM encoding, instruction
// class codes, MIPS-style opcode constants and instruction field positions.
package fetch_decode_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fdState_t;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int JADDR_LSB = 0;

  function automatic logic [1:0] instrType(input logic [5:0] op);
    if (op == OP_R) return TYPE_R;
    if (op == OP_J || op == OP_JAL) return TYPE_J;
    return TYPE_I;
  endfunction

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Control, memory-load and decoded-instruction signals of the fetch/decode
// stage; slave is the stage itself, master is whoever drives it.
interface fetch_decode_stage_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] initialPC_FD;
  logic              start_FD;
  logic              stall_FD;
  logic              redirect_FD;
  logic [ADDR_W-1:0] redirectAddr_FD;
  logic              imemWe_FD;
  logic [ADDR_W-3:0] imemWAddr_FD;
  logic [31:0]       imemWData_FD;

  logic [5:0]        op_FD;
  logic [4:0]        rs_FD;
  logic [4:0]        rt_FD;
  logic [4:0]        rd_FD;
  logic [4:0]        shamt_FD;
  logic [5:0]        funct_FD;
  logic [15:0]       imm_FD;
  logic [25:0]       jaddr_FD;
  logic [1:0]        type_FD;
  logic [ADDR_W-1:0] pcOut_FD;
  logic              valid_FD;
  logic              halted_FD;

  modport master (
    output initialPC_FD, start_FD, stall_FD, redirect_FD, redirectAddr_FD,
           imemWe_FD, imemWAddr_FD, imemWData_FD,
    input  op_FD, rs_FD, rt_FD, rd_FD, shamt_FD, funct_FD, imm_FD, jaddr_FD,
           type_FD, pcOut_FD, valid_FD, halted_FD
  );

  modport slave (
    input  initialPC_FD, start_FD, stall_FD, redirect_FD, redirectAddr_FD,
           imemWe_FD, imemWAddr_FD, imemWData_FD,
    output op_FD, rs_FD, rt_FD, rd_FD, shamt_FD, funct_FD, imm_FD, jaddr_FD,
           type_FD, pcOut_FD, valid_FD, halted_FD
  );
endinterface

// File: rtl/fetch_decode_stage_imem_sync.sv
// DEPTH x 32 instruction memory: one write port, one registered read port.
// The read register doubles as the instruction register and is cleared by reset.
module imem_sync #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wIdx,
  input  logic [31:0]      wData,
  input  logic             re,
  input  logic [IDX_W-1:0] rIdx,
  output logic [31:0]      rData
);

  logic [31:0] mem [DEPTH];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[wIdx] <= wData;
  end

  // Read-before-write: a same-edge write is not seen by this read.
  always_ff @(posedge clk) begin
    if (!rst_n)  rData <= '0;
    else if (re) rData <= mem[rIdx];
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode stage: IDLE/RUN/HALT fetch FSM driving a synchronous
// instruction memory, with combinational field decode of the fetched word.
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter int         ADDR_W  = 8,
  parameter int         DEPTH   = 2**(ADDR_W-2),
  parameter int         PC_STEP = 4,
  parameter logic [5:0] HALT_OP = OP_HALT
) (
  input logic               clk_FD,
  input logic               rst_n_FD,
  fetch_decode_stage_if.slave fd
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

  function automatic logic [IDX_W-1:0] wordIdx(input logic [ADDR_W-3:0] w);
    return IDX_W'(32'(w) % 32'(DEPTH));
  endfunction

  fdState_t          state;
  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] pcOut_p1;
  logic              vld_p1;
  logic              halted_p1;
  logic [31:0]       ir_p1;
  logic              haltSeen;
  logic              rdEn;

  assign haltSeen = vld_p1 && (ir_p1[OP_LSB +: 6] == HALT_OP);
  // Fetch only on a plain advance; redirect, stall and halt all suppress it.
  assign rdEn = (state == ST_RUN) && !fd.redirect_FD && !fd.stall_FD && !haltSeen;

  // p0 -> p1: PC issued to memory, word lands in IR one edge later
  imem_sync #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_imem (
    .clk   (clk_FD),
    .rst_n (rst_n_FD),
    .we    (fd.imemWe_FD),
    .wIdx  (wordIdx(fd.imemWAddr_FD)),
    .wData (fd.imemWData_FD),
    .re    (rdEn),
    .rIdx  (wordIdx(pc_p0[ADDR_W-1:2])),
    .rData (ir_p1)
  );

  always_ff @(posedge clk_FD) begin
    if (!rst_n_FD) begin
      state     <= ST_IDLE;
      pc_p0     <= '0;
      pcOut_p1  <= '0;
      vld_p1    <= 1'b0;
      halted_p1 <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (fd.start_FD) begin
            pc_p0 <= fd.initialPC_FD;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fd.redirect_FD) begin
            pc_p0  <= fd.redirectAddr_FD;
            vld_p1 <= 1'b0;
          end else if (!fd.stall_FD) begin
            if (haltSeen) begin
              state     <= ST_HALT;
              halted_p1 <= 1'b1;
              vld_p1    <= 1'b0;
            end else begin
              pc_p0    <= pc_p0 + PC_INC;
              pcOut_p1 <= pc_p0;
              vld_p1   <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (fd.redirect_FD) begin
            pc_p0     <= fd.redirectAddr_FD;
            state     <= ST_RUN;
            halted_p1 <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // p1: decode straight from IR
  assign fd.op_FD     = ir_p1[OP_LSB +: 6];
  assign fd.rs_FD     = ir_p1[RS_LSB +: 5];
  assign fd.rt_FD     = ir_p1[RT_LSB +: 5];
  assign fd.rd_FD     = ir_p1[RD_LSB +: 5];
  assign fd.shamt_FD  = ir_p1[SHAMT_LSB +: 5];
  assign fd.funct_FD  = ir_p1[FUNCT_LSB +: 6];
  assign fd.imm_FD    = ir_p1[IMM_LSB +: 16];
  assign fd.jaddr_FD  = ir_p1[JADDR_LSB +: 26];
  assign fd.type_FD   = instrType(ir_p1[OP_LSB +: 6]);
  assign fd.pcOut_FD  = pcOut_p1;
  assign fd.valid_FD  = vld_p1;
  assign fd.halted_FD = halted_p1;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: decode vector table, directed stall/redirect/
// wrap/halt/reset sequences, then random traffic against a behavioural model.
module tb_fetch_decode_stage;

  logic clk;
  logic rstN;
  int   total;
  int   bad;

  fetch_decode_stage_if #(.ADDR_W(8)) fdIf ();

  fetch_decode_stage #(.ADDR_W(8)) dut (
    .clk_FD   (clk),
    .rst_n_FD (rstN),
    .fd       (fdIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] ja;
    logic [1:0]  ty;
  } vec_t;

  vec_t tbl [5];

  // Behavioural reference: a memory image plus the architectural view.
  logic [31:0] mMem [64];
  bit          mIdle;
  bit          mHalt;
  logic [7:0]  mPc;
  logic [7:0]  mPcOut;
  logic [31:0] mIr;
  bit          mVld;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] classOf(input logic [31:0] w);
    int op;
    op = int'(w >> 26);
    if (op == 0) return 2'b00;
    if (op == 2 || op == 3) return 2'b10;
    return 2'b01;
  endfunction

  task automatic tick();
    logic [31:0] fetched;
    logic [85:0] act;
    logic [85:0] exp;
    @(posedge clk);
    fetched = mMem[mPc >> 2];
    if (!rstN) begin
      mIdle = 1; mHalt = 0; mPc = 0; mPcOut = 0; mIr = 0; mVld = 0;
    end else if (mIdle) begin
      if (fdIf.start_FD) begin mPc = fdIf.initialPC_FD; mIdle = 0; end
    end else if (mHalt) begin
      if (fdIf.redirect_FD) begin mPc = fdIf.redirectAddr_FD; mHalt = 0; end
    end else if (fdIf.redirect_FD) begin
      mPc = fdIf.redirectAddr_FD; mVld = 0;
    end else if (!fdIf.stall_FD) begin
      if (mVld && (mIr >> 26) == 32'h3F) begin
        mHalt = 1; mVld = 0;
      end else begin
        mIr = fetched; mPcOut = mPc; mVld = 1; mPc = mPc + 8'd4;
      end
    end
    if (fdIf.imemWe_FD) mMem[fdIf.imemWAddr_FD] = fdIf.imemWData_FD;
    #1;
    act = {fdIf.op_FD, fdIf.rs_FD, fdIf.rt_FD, fdIf.rd_FD, fdIf.shamt_FD,
           fdIf.funct_FD, fdIf.imm_FD, fdIf.jaddr_FD, fdIf.type_FD,
           fdIf.pcOut_FD, fdIf.valid_FD, fdIf.halted_FD};
    exp = {6'(mIr >> 26), 5'(mIr >> 21), 5'(mIr >> 16), 5'(mIr >> 11), 5'(mIr >> 6),
           6'(mIr), 16'(mIr), 26'(mIr), classOf(mIr), mPcOut, mVld, mHalt};
    chk("model", 128'(act), 128'(exp));
  endtask

  task automatic quiet();
    fdIf.start_FD = 0; fdIf.stall_FD = 0; fdIf.redirect_FD = 0;
    fdIf.imemWe_FD = 0;
  endtask

  task automatic doReset();
    quiet();
    rstN = 0;
    tick();
    rstN = 1;
  endtask

  task automatic startAt(input logic [7:0] a);
    fdIf.initialPC_FD = a;
    fdIf.start_FD = 1;
    tick();
    fdIf.start_FD = 0;
  endtask

  initial begin
    total = 0; bad = 0;
    tbl[0] = '{32'h012A4020, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h4020, 26'h012A4020, 2'b00};
    tbl[1] = '{32'h08000010, 6'h02, 5'd0, 5'd0,  5'd0, 5'd0, 6'h10, 16'h0010, 26'h0000010, 2'b10};
    tbl[2] = '{32'h8D090004, 6'h23, 5'd8, 5'd9,  5'd0, 5'd0, 6'h04, 16'h0004, 26'h1090004, 2'b01};
    tbl[3] = '{32'h0C0000FF, 6'h03, 5'd0, 5'd0,  5'd0, 5'd3, 6'h3F, 16'h00FF, 26'h00000FF, 2'b10};
    tbl[4] = '{32'h00094100, 6'h00, 5'd0, 5'd9,  5'd8, 5'd4, 6'h00, 16'h4100, 26'h0094100, 2'b00};

    rstN = 0;
    quiet();
    fdIf.initialPC_FD = 0; fdIf.redirectAddr_FD = 0;
    fdIf.imemWAddr_FD = 0; fdIf.imemWData_FD = 0;

    // Preload the whole memory while held in reset.
    for (int i = 0; i < 64; i++) begin
      fdIf.imemWe_FD = 1;
      fdIf.imemWAddr_FD = 6'(i);
      fdIf.imemWData_FD = (i < 5) ? tbl[i].w : (32'h20000000 | 32'(i));
      tick();
    end
    fdIf.imemWe_FD = 0;
    tick();
    chk("rstPcOut", 128'(fdIf.pcOut_FD), 128'h0);
    chk("rstValid", 128'(fdIf.valid_FD), 128'h0);
    chk("rstHalted", 128'(fdIf.halted_FD), 128'h0);
    chk("rstOpType", 128'({fdIf.op_FD, fdIf.type_FD, fdIf.jaddr_FD}), 128'h0);

    // Decode table: sequential fetch from 0 through words 0..4.
    rstN = 1;
    startAt(8'h00);
    chk("startValid", 128'(fdIf.valid_FD), 128'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("tblPc", 128'(fdIf.pcOut_FD), 128'(8'(i * 4)));
      chk("tblValid", 128'(fdIf.valid_FD), 128'h1);
      chk("tblFields", 128'({fdIf.op_FD, fdIf.rs_FD, fdIf.rt_FD, fdIf.rd_FD, fdIf.shamt_FD,
                             fdIf.funct_FD, fdIf.imm_FD, fdIf.jaddr_FD, fdIf.type_FD}),
          128'({tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sh,
                tbl[i].fn, tbl[i].imm, tbl[i].ja, tbl[i].ty}));
    end

    // Stall for three cycles at 0x08, resume, then stall+redirect to 0x40.
    doReset();
    startAt(8'h00);
    tick(); tick(); tick();
    chk("preStallPc", 128'(fdIf.pcOut_FD), 128'h08);
    fdIf.stall_FD = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stallPc", 128'(fdIf.pcOut_FD), 128'h08);
      chk("stallValid", 128'(fdIf.valid_FD), 128'h1);
      chk("stallIr", 128'(fdIf.jaddr_FD), 128'h1090004);
    end
    fdIf.stall_FD = 0;
    tick();
    chk("resumePc", 128'(fdIf.pcOut_FD), 128'h0C);
    fdIf.stall_FD = 1; fdIf.redirect_FD = 1; fdIf.redirectAddr_FD = 8'h40;
    tick();
    chk("redirSquash", 128'(fdIf.valid_FD), 128'h0);
    quiet();
    tick();
    chk("redirPc", 128'({fdIf.pcOut_FD, fdIf.valid_FD}), 128'({8'h40, 1'b1}));
    chk("redirWord", 128'(fdIf.imm_FD), 128'h0010);

    // PC wrap at the top of the 8-bit address space.
    doReset();
    startAt(8'hF8);
    tick(); chk("wrapF8", 128'(fdIf.pcOut_FD), 128'hF8);
    tick(); chk("wrapFC", 128'(fdIf.pcOut_FD), 128'hFC);
    tick(); chk("wrap00", 128'({fdIf.pcOut_FD, fdIf.valid_FD}), 128'({8'h00, 1'b1}));

    // Halt word at 0x10, start ignored while halted, redirect resumes.
    rstN = 0;
    fdIf.imemWe_FD = 1; fdIf.imemWAddr_FD = 6'd4; fdIf.imemWData_FD = 32'hFC000000;
    tick();
    quiet();
    rstN = 1;
    startAt(8'h00);
    for (int i = 0; i < 5; i++) tick();
    chk("haltWordPc", 128'({fdIf.pcOut_FD, fdIf.op_FD}), 128'({8'h10, 6'h3F}));
    tick();
    chk("halted", 128'({fdIf.halted_FD, fdIf.valid_FD}), 128'({1'b1, 1'b0}));
    fdIf.start_FD = 1; fdIf.initialPC_FD = 8'h20;
    tick(); tick();
    chk("haltIgnStart", 128'({fdIf.halted_FD, fdIf.valid_FD}), 128'({1'b1, 1'b0}));
    quiet();
    fdIf.redirect_FD = 1; fdIf.redirectAddr_FD = 8'h00;
    tick();
    chk("unhalt", 128'({fdIf.halted_FD, fdIf.valid_FD}), 128'h0);
    quiet();
    tick();
    chk("unhaltPc", 128'({fdIf.pcOut_FD, fdIf.valid_FD}), 128'({8'h00, 1'b1}));

    // Reset mid-run clears everything in one edge; memory keeps its contents.
    tick(); tick();
    fdIf.stall_FD = 1; fdIf.redirect_FD = 1; fdIf.start_FD = 1;
    rstN = 0;
    tick();
    chk("midRst", 128'({fdIf.op_FD, fdIf.rs_FD, fdIf.rt_FD, fdIf.rd_FD, fdIf.shamt_FD,
                        fdIf.funct_FD, fdIf.imm_FD, fdIf.jaddr_FD, fdIf.type_FD,
                        fdIf.pcOut_FD, fdIf.valid_FD, fdIf.halted_FD}), 128'h0);
    quiet();
    rstN = 1;
    tick();
    chk("idleAfterRst", 128'(fdIf.valid_FD), 128'h0);
    startAt(8'h00);
    tick();
    chk("memKeep", 128'({fdIf.op_FD, fdIf.jaddr_FD}), 128'({6'h00, 26'h012A4020}));

    // Random traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      rstN = ($urandom_range(0, 99) != 0);
      fdIf.start_FD = ($urandom_range(0, 3) == 0);
      fdIf.initialPC_FD = 8'($urandom);
      fdIf.stall_FD = ($urandom_range(0, 3) == 0);
      fdIf.redirect_FD = ($urandom_range(0, 9) == 0);
      fdIf.redirectAddr_FD = 8'($urandom);
      fdIf.imemWe_FD = ($urandom_range(0, 4) == 0);
      fdIf.imemWAddr_FD = 6'($urandom);
      fdIf.imemWData_FD = ($urandom_range(0, 7) == 0) ? {6'h3F, 26'($urandom)} : 32'($urandom);
      tick();
    end

    quiet();
    rstN = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 Parameter ADDR_W, default 8: PC / byte-address width.
REQ-002 Parameter DEPTH, default 2**(ADDR_W-2): instruction memory words; DEPTH SHALL be at most 2**(ADDR_W-2).
REQ-003 Parameter PC_STEP, default 4: sequential PC increment in bytes.
REQ-004 Parameter HALT_OP, default 6'b111111: opcode that halts fetch.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset, with these ports:
- clk_FD  in  1  the only clock; all state changes on its rising edge.
- rst_n_FD  in  1  synchronous, active-low reset.
- initialPC_FD  in  ADDR_W  start address, loaded on start.
- start_FD  in  1  leaves IDLE.
- stall_FD  in  1  holds PC and instruction register.
- redirect_FD  in  1  branch/jump redirect request.
- redirectAddr_FD  in  ADDR_W  redirect target.
- imemWe_FD  in  1  instruction memory write enable.
- imemWAddr_FD  in  ADDR_W-2  word write address.
- imemWData_FD  in  32  write data.
- op_FD  out  6  IR[31:26].
- rs_FD  out  5  IR[25:21].
- rt_FD  out  5  IR[20:16].
- rd_FD  out  5  IR[15:11].
- shamt_FD  out  5  IR[10:6].
- funct_FD  out  6  IR[5:0].
- imm_FD  out  16  IR[15:0].
- jaddr_FD  out  26  IR[25:0].
- type_FD  out  2  00=R (op 0), 10=J (op 2/3), 01=I (otherwise).
- pcOut_FD  out  ADDR_W  address of the instruction in IR.
- valid_FD  out  1  IR holds a live instruction.
- halted_FD  out  1  high in HALT.

Function
REQ-006 FSM states: IDLE, RUN, HALT. IDLE->RUN on start_FD (PC<=initialPC_FD); RUN->HALT when a valid instruction with op==HALT_OP is not flushed; HALT->RUN only on redirect_FD (PC<=redirectAddr_FD); start_FD ignored outside IDLE.
REQ-007 Memory read SHALL be synchronous: PC issued in cycle N -> IR, pcOut_FD, valid_FD=1 visible after edge N+1 (1-cycle latency); decode fields combinational from IR.
REQ-008 In RUN without stall/redirect, PC SHALL advance by PC_STEP each cycle, modulo 2**ADDR_W (0xFC+4 -> 0x00 at ADDR_W=8).
REQ-009 Memory word index SHALL be PC[ADDR_W-1:2], further taken modulo DEPTH.
REQ-010 stall_FD=1: PC, IR, pcOut_FD, valid_FD held unchanged.
REQ-011 redirect_FD=1: PC<=redirectAddr_FD, valid_FD=0 for the next cycle (in-flight fetch squashed); target instruction valid one cycle later.
REQ-012 redirect_FD and stall_FD together: redirect wins.
REQ-013 In IDLE and HALT: valid_FD=0, PC frozen, no fetch effects.
REQ-014 Memory writes SHALL be accepted in every state; a same-cycle read of the written word returns old data.
REQ-015 HALT_OP detection SHALL not occur on a squashed or invalid IR.

Reset
REQ-016 With rst_n_FD=0 at a clock edge: state=IDLE, PC=0, IR=0, pcOut_FD=0, valid_FD=0, halted_FD=0; all decode outputs are therefore 0 and type_FD=00.
REQ-017 Reset SHALL take priority over start, stall, and redirect, and SHALL abort any state in one edge; memory contents are not cleared.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding, the type_FD codes, the R/J/HALT opcode constants, and the field bit positions.
REQ-019 Instruction memory SHALL be a sub-module imem_sync (DEPTH x 32, one write port, one synchronous read port); all else is in fetch_decode_stage.

Verification
REQ-020 Load words 0..3 via write port, reset, initialPC=0x00, start -> pcOut 0x00,0x04,0x08,0x0C on consecutive cycles, valid=1 from the cycle after start+1.
REQ-021 Word 0x012A4020 (add $8,$9,$10) -> op=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20, type=00; 0x08000010 -> type=10, jaddr=0x10.
REQ-022 Stall held 3 cycles at pcOut=0x08 -> outputs frozen at 0x08, resume at 0x0C; stall+redirect to 0x40 together -> valid=0 one cycle, then pcOut=0x40.
REQ-023 initialPC=0xF8, ADDR_W=8 -> pcOut 0xF8,0xFC,0x00.
REQ-024 Word 0xFC000000 at 0x10 -> halted=1, valid=0 afterwards; redirect to 0x00 -> RUN, pcOut=0x00.
REQ-025 Assert rst_n_FD=0 mid-run -> all outputs 0 and IDLE after one edge; memory contents unchanged after a restart.
